// File: rtl/async_fifo_rd_stream.sv
// async_fifo_rd_stream: read-domain drain engine that turns FIFO reads into a valid/ready stream
// with a 2-entry credit-managed skid buffer, a transfer counter and an idle flag.
module async_fifo_rd_stream #(
   parameter int DATA_WIDTH = 8,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  rd_clk,
   input  logic                  rd_rst,
   input  logic                  enable,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] data_out,
   output logic                  rd_en,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [CNT_WIDTH-1:0]  xfer_count,
   output logic                  idle
);
   logic [DATA_WIDTH-1:0] mem [2];
   logic                  head;
   logic                  tail;
   logic                  inflight;
   logic [1:0]            occ;
   logic [1:0]            occ_next;
   logic                  pop;
   // occ_next doubles as the committed credit: a new read is allowed only while it stays below 2
   always_comb begin
      m_valid  = occ != 2'd0;
      m_data   = mem[head];
      idle     = (occ == 2'd0) & ~inflight;
      pop      = m_valid & m_ready;
      occ_next = occ + {1'b0, inflight} - {1'b0, pop};
      rd_en    = rd_rst & enable & ~fifo_empty & (occ_next < 2'd2);
   end
   always_ff @(posedge rd_clk or negedge rd_rst) begin
      if (!rd_rst) begin
         mem[0]     <= '0;
         mem[1]     <= '0;
         head       <= 1'b0;
         tail       <= 1'b0;
         inflight   <= 1'b0;
         occ        <= 2'd0;
         xfer_count <= '0;
      end else begin
         inflight <= rd_en;
         occ      <= occ_next;
         if (inflight) begin
            mem[tail] <= data_out;
            tail      <= ~tail;
         end
         if (pop) begin
            head       <= ~head;
            xfer_count <= xfer_count + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_async_fifo_rd_stream.sv
// tb_async_fifo_rd_stream: directed and soak checks of the read-side drain engine against a FIFO model.
module tb_async_fifo_rd_stream;
   localparam int DW = 8;
   localparam int CW = 4;
   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          enable = 1'b0;
   logic          fifo_empty;
   logic [DW-1:0] data_out = '0;
   logic          rd_en;
   logic [DW-1:0] m_data;
   logic          m_valid;
   logic          m_ready = 1'b0;
   logic [CW-1:0] xfer_count;
   logic          idle;
   logic          hold_empty = 1'b0;
   logic [7:0]    mem [1024];
   logic [7:0]    recv [4096];
   int            recv_cyc [4096];
   int            wptr = 0, rptr = 0;
   int            checks = 0, errors = 0;
   int            nrecv = 0, rd_cnt = 0, viol = 0, stall_viol = 0, cyc = 0;
   logic          prev_stall = 1'b0;
   logic [7:0]    prev_data = '0;

   async_fifo_rd_stream #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
      .rd_clk(clk), .rd_rst(rst_n), .enable(enable), .fifo_empty(fifo_empty),
      .data_out(data_out), .rd_en(rd_en), .m_data(m_data), .m_valid(m_valid),
      .m_ready(m_ready), .xfer_count(xfer_count), .idle(idle)
   );

   always #5 clk = ~clk;
   assign fifo_empty = (wptr == rptr) | hold_empty;

   // FIFO read port model plus stream monitor
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!rst_n) begin
         rptr       <= wptr;
         prev_stall <= 1'b0;
      end else begin
         if (rd_en) begin
            data_out <= mem[rptr[9:0]];
            rptr     <= rptr + 1;
            rd_cnt   <= rd_cnt + 1;
            if (fifo_empty) viol <= viol + 1;
         end
         if (m_valid && m_ready) begin
            recv[nrecv[11:0]]     <= m_data;
            recv_cyc[nrecv[11:0]] <= cyc;
            nrecv                 <= nrecv + 1;
         end
         if (prev_stall && (!m_valid || m_data !== prev_data)) stall_viol <= stall_viol + 1;
         prev_stall <= m_valid && !m_ready;
         prev_data  <= m_data;
      end
   end

   task automatic push(input logic [7:0] d);
      mem[wptr[9:0]] = d;
      wptr++;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0; enable = 1'b0; m_ready = 1'b0; hold_empty = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic wait_recv(input int target, input int budget);
      for (int i = 0; i < budget && nrecv < target; i++) @(negedge clk);
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst_n = 1'b0; enable = 1'b1; m_ready = 1'b1;
      push(8'h99);
      repeat (2) @(negedge clk);
      #1;
      checks++; if (rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en got %b want 0", rd_en); end
      checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got %b want 0", m_valid); end
      checks++; if (m_data !== 8'h00) begin errors++; $display("FAIL reset_m_data got %h want 00", m_data); end
      checks++; if (xfer_count !== 4'd0) begin errors++; $display("FAIL reset_xfer got %0d want 0", xfer_count); end
      checks++; if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle got %b want 1", idle); end
      @(negedge clk);
      enable = 1'b0; m_ready = 1'b0; rst_n = 1'b1;
   endtask

   task automatic test_single();
      apply_reset();
      @(negedge clk);
      enable = 1'b1; m_ready = 1'b1;
      push(8'hA5);
      #1;
      checks++; if (rd_en !== 1'b1) begin errors++; $display("FAIL single_rd_en_t0 got %b want 1", rd_en); end
      @(negedge clk); #1;
      checks++; if (rd_en !== 1'b0) begin errors++; $display("FAIL single_rd_en_t1 got %b want 0", rd_en); end
      checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL single_valid_t1 got %b want 0", m_valid); end
      checks++; if (idle !== 1'b0) begin errors++; $display("FAIL single_idle_t1 got %b want 0", idle); end
      @(negedge clk); #1;
      checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL single_valid_t2 got %b want 1", m_valid); end
      checks++; if (m_data !== 8'hA5) begin errors++; $display("FAIL single_data_t2 got %h want a5", m_data); end
      @(negedge clk); #1;
      checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL single_valid_t3 got %b want 0", m_valid); end
      checks++; if (xfer_count !== 4'd1) begin errors++; $display("FAIL single_xfer got %0d want 1", xfer_count); end
      checks++; if (idle !== 1'b1) begin errors++; $display("FAIL single_idle_t3 got %b want 1", idle); end
   endtask

   task automatic test_streaming();
      int base, v0, k;
      apply_reset();
      base = nrecv; v0 = viol;
      @(negedge clk);
      enable = 1'b1; m_ready = 1'b1;
      for (int i = 0; i < 16; i++) push(8'(i));
      wait_recv(base + 16, 40);
      checks++; if (nrecv - base != 16) begin errors++; $display("FAIL stream_count got %0d want 16", nrecv - base); end
      for (int i = 0; i < 16; i++) begin
         k = base + i;
         checks++; if (recv[k[11:0]] !== 8'(i)) begin errors++; $display("FAIL stream_order[%0d] got %h want %h", i, recv[k[11:0]], 8'(i)); end
      end
      k = base + 15;
      checks++; if (recv_cyc[k[11:0]] - recv_cyc[base[11:0]] != 15) begin
         errors++; $display("FAIL stream_span got %0d want 15", recv_cyc[k[11:0]] - recv_cyc[base[11:0]]);
      end
      @(negedge clk); #1;
      checks++; if (xfer_count !== 4'd0) begin errors++; $display("FAIL stream_xfer got %0d want 0 (16 mod 16)", xfer_count); end
      checks++; if (viol != v0) begin errors++; $display("FAIL stream_rd_en_when_empty got %0d want 0", viol - v0); end
   endtask

   task automatic test_backpressure();
      int base, r0, k;
      apply_reset();
      base = nrecv; r0 = rd_cnt;
      @(negedge clk);
      enable = 1'b1; m_ready = 1'b0;
      for (int i = 0; i < 4; i++) push(8'(8'h10 + i));
      for (int i = 0; i < 10; i++) begin
         @(negedge clk); #1;
         if (m_valid) begin
            checks++; if (m_data !== 8'h10) begin errors++; $display("FAIL bp_hold_data got %h want 10", m_data); end
         end
      end
      checks++; if (rd_cnt - r0 != 2) begin errors++; $display("FAIL bp_rd_pulses got %0d want 2", rd_cnt - r0); end
      checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL bp_valid got %b want 1", m_valid); end
      m_ready = 1'b1;
      wait_recv(base + 4, 20);
      checks++; if (nrecv - base != 4) begin errors++; $display("FAIL bp_count got %0d want 4", nrecv - base); end
      for (int i = 0; i < 4; i++) begin
         k = base + i;
         checks++; if (recv[k[11:0]] !== 8'(8'h10 + i)) begin errors++; $display("FAIL bp_order[%0d] got %h want %h", i, recv[k[11:0]], 8'(8'h10 + i)); end
      end
      checks++; if (stall_viol != 0) begin errors++; $display("FAIL bp_stream_stable got %0d want 0", stall_viol); end
   endtask

   task automatic test_enable_drop();
      int base, r0;
      apply_reset();
      base = nrecv; r0 = rd_cnt;
      @(negedge clk);
      enable = 1'b1; m_ready = 1'b1;
      push(8'h20); push(8'h21);
      #1;
      checks++; if (rd_en !== 1'b1) begin errors++; $display("FAIL en_rd_en_t0 got %b want 1", rd_en); end
      @(negedge clk);
      enable = 1'b0;
      #1;
      checks++; if (rd_en !== 1'b0) begin errors++; $display("FAIL en_rd_en_off got %b want 0", rd_en); end
      repeat (5) @(negedge clk);
      #1;
      checks++; if (nrecv - base != 1) begin errors++; $display("FAIL en_inflight_count got %0d want 1", nrecv - base); end
      checks++; if (recv[base[11:0]] !== 8'h20) begin errors++; $display("FAIL en_inflight_data got %h want 20", recv[base[11:0]]); end
      checks++; if (rd_cnt - r0 != 1) begin errors++; $display("FAIL en_rd_pulses got %0d want 1", rd_cnt - r0); end
      checks++; if (idle !== 1'b1) begin errors++; $display("FAIL en_idle got %b want 1", idle); end
      enable = 1'b1;
      wait_recv(base + 2, 10);
      checks++; if (nrecv - base != 2) begin errors++; $display("FAIL en_resume_count got %0d want 2", nrecv - base); end
      checks++; if (recv[12'(base + 1)] !== 8'h21) begin errors++; $display("FAIL en_resume_data got %h want 21", recv[12'(base + 1)]); end
   endtask

   task automatic test_async_reset();
      int base;
      apply_reset();
      base = nrecv;
      @(negedge clk);
      enable = 1'b1; m_ready = 1'b1;
      for (int i = 0; i < 6; i++) push(8'(8'h30 + i));
      wait_recv(base + 2, 20);
      m_ready = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL ar_pre_valid got %b want 1", m_valid); end
      checks++; if (m_data !== 8'h32) begin errors++; $display("FAIL ar_pre_data got %h want 32", m_data); end
      checks++; if (xfer_count !== 4'd2) begin errors++; $display("FAIL ar_pre_xfer got %0d want 2", xfer_count); end
      checks++; if (rd_en !== 1'b0) begin errors++; $display("FAIL ar_pre_rd_en got %b want 0", rd_en); end
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL ar_valid got %b want 0", m_valid); end
      checks++; if (rd_en !== 1'b0) begin errors++; $display("FAIL ar_rd_en got %b want 0", rd_en); end
      checks++; if (xfer_count !== 4'd0) begin errors++; $display("FAIL ar_xfer got %0d want 0", xfer_count); end
      checks++; if (m_data !== 8'h00) begin errors++; $display("FAIL ar_data got %h want 00", m_data); end
      checks++; if (idle !== 1'b1) begin errors++; $display("FAIL ar_idle got %b want 1", idle); end
      enable = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_counter_wrap();
      int base, k;
      apply_reset();
      base = nrecv;
      @(negedge clk);
      enable = 1'b1; m_ready = 1'b1;
      for (int i = 0; i < 17; i++) push(8'(8'h40 + i));
      wait_recv(base + 17, 60);
      checks++; if (nrecv - base != 17) begin errors++; $display("FAIL wrap_count got %0d want 17", nrecv - base); end
      for (int i = 0; i < 17; i++) begin
         k = base + i;
         checks++; if (recv[k[11:0]] !== 8'(8'h40 + i)) begin errors++; $display("FAIL wrap_order[%0d] got %h want %h", i, recv[k[11:0]], 8'(8'h40 + i)); end
      end
      @(negedge clk); #1;
      checks++; if (xfer_count !== 4'd1) begin errors++; $display("FAIL wrap_xfer got %0d want 1", xfer_count); end
   endtask

   task automatic test_soak();
      int base, start, bad, s0, v0, k, j;
      apply_reset();
      base = nrecv; start = wptr; s0 = stall_viol; v0 = viol; bad = 0;
      @(negedge clk);
      enable = 1'b1;
      for (int i = 0; i < 80; i++) push(8'($urandom_range(0, 255)));
      for (int i = 0; i < 3000 && nrecv < base + 80; i++) begin
         @(negedge clk);
         m_ready = 1'($urandom_range(0, 1));
         hold_empty = ($urandom_range(0, 3) == 0);
      end
      hold_empty = 1'b0; m_ready = 1'b1;
      checks++; if (nrecv - base != 80) begin errors++; $display("FAIL soak_count got %0d want 80", nrecv - base); end
      for (int i = 0; i < 80; i++) begin
         k = base + i; j = start + i;
         if (recv[k[11:0]] !== mem[j[9:0]]) bad++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL soak_order got %0d bad words want 0", bad); end
      checks++; if (stall_viol != s0) begin errors++; $display("FAIL soak_stream_stable got %0d want 0", stall_viol - s0); end
      checks++; if (viol != v0) begin errors++; $display("FAIL soak_rd_en_when_empty got %0d want 0", viol - v0); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_streaming();
      test_backpressure();
      test_enable_drop();
      test_async_reset();
      test_counter_wrap();
      test_soak();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end
endmodule
